g11620_emu: RTL

- Synthesizable responder model of the G11620 linear image sensor, for board bring-up and regression without the physical sensor.
- Sits on the sensor side of the controller interface. It consumes the controller's reset pulse, measures integration length, raises the AD start pulse (ad_sp), then streams one line of pixel words.
- Output feeds the capture path in place of the external ADC data.

---
 rtl/g11620_emu_pkg.sv | 22 ++
 rtl/g11620_emu_pattern.sv | 26 ++
 rtl/g11620_emu.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/g11620_emu_pkg.sv
// rtl/g11620_emu_pkg.sv - shared state, pattern and default constants for the G11620 sensor responder
package g11620_emu_pkg;

   typedef enum logic [2:0] {
      EMU_IDLE  = 3'd0,
      EMU_INTEG = 3'd1,
      EMU_DLY   = 3'd2,
      EMU_SP    = 3'd3,
      EMU_READ  = 3'd4
   } emu_state_e;

   localparam logic [1:0] PAT_RAMP  = 2'd0;
   localparam logic [1:0] PAT_CONST = 2'd1;
   localparam logic [1:0] PAT_INTEG = 2'd2;
   localparam logic [1:0] PAT_CHECK = 2'd3;

   localparam logic [8:0]  PIX_NUM_DEF   = 9'd511;
   localparam logic [7:0]  SP_DLY_DEF    = 8'd16;
   localparam logic [31:0] MIN_INTEG_DEF = 32'd4;
   localparam int          DW_DEF        = 16;

endpackage

// File: rtl/g11620_emu_pattern.sv
// rtl/g11620_emu_pattern.sv - combinational pixel word generator for the selected test pattern
module g11620_emu_pattern
   import g11620_emu_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic [1:0]    mode_i,
   input  logic [8:0]    pix_i,
   input  logic [31:0]   integ_len_i,
   input  logic [DW-1:0] const_i,
   input  logic          frame_lsb_i,
   output logic [DW-1:0] data_o
);

   always_comb begin
      data_o = '0;
      case (mode_i)
         PAT_RAMP:  data_o = DW'(pix_i);
         PAT_CONST: data_o = const_i;
         PAT_INTEG: data_o = integ_len_i[DW-1:0] + DW'(pix_i);
         PAT_CHECK: data_o = {DW{pix_i[0] ^ frame_lsb_i}};
         default:   data_o = '0;
      endcase
   end

endmodule

// File: rtl/g11620_emu.sv
// rtl/g11620_emu.sv - G11620 linear sensor responder: measures integration, pulses ad_sp, streams one line
module g11620_emu
   import g11620_emu_pkg::*;
#(
   parameter logic [8:0]  PIX_NUM   = PIX_NUM_DEF,
   parameter logic [7:0]  SP_DLY    = SP_DLY_DEF,
   parameter logic [31:0] MIN_INTEG = MIN_INTEG_DEF,
   parameter int          DW        = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          reset_in,
   input  logic [1:0]    pattern_sel,
   input  logic [DW-1:0] const_val,
   output logic          ad_sp_o,
   output logic          video_valid_o,
   output logic [DW-1:0] video_data_o,
   output logic [8:0]    pix_idx_o,
   output logic [31:0]   integ_len_o,
   output logic [15:0]   frame_cnt_o,
   output logic          short_err_o,
   output logic          abort_err_o
);

   emu_state_e    state_q, state_d;
   logic          reset_d_q, reset_d_d;
   logic [31:0]   integ_cnt_q, integ_cnt_d;
   logic [7:0]    dly_cnt_q, dly_cnt_d;
   logic [1:0]    mode_q, mode_d;
   logic [DW-1:0] const_q, const_d;
   logic          ad_sp_q, ad_sp_d;
   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;
   logic [8:0]    pix_q, pix_d;
   logic [31:0]   integ_len_q, integ_len_d;
   logic [15:0]   frame_q, frame_d;
   logic          short_q, short_d;
   logic          abort_q, abort_d;

   logic          rise, fall, in_sp;
   logic [DW-1:0] pat_data;

   assign rise  = reset_in & ~reset_d_q;
   assign fall  = ~reset_in & reset_d_q;
   assign in_sp = (state_q == EMU_SP);

   // In SP the pattern inputs are taken live so pixel 0 already uses the values being latched.
   g11620_emu_pattern #(.DW(DW)) u_pattern (
      .mode_i      (in_sp ? pattern_sel : mode_q),
      .pix_i       (in_sp ? 9'd0 : pix_q + 9'd1),
      .integ_len_i (integ_len_q),
      .const_i     (in_sp ? const_val : const_q),
      .frame_lsb_i (frame_q[0]),
      .data_o      (pat_data)
   );

   always_comb begin
      state_d     = state_q;
      reset_d_d   = reset_in;
      integ_cnt_d = integ_cnt_q;
      dly_cnt_d   = dly_cnt_q;
      mode_d      = mode_q;
      const_d     = const_q;
      ad_sp_d     = 1'b0;
      valid_d     = valid_q;
      data_d      = data_q;
      pix_d       = pix_q;
      integ_len_d = integ_len_q;
      frame_d     = frame_q;
      short_d     = short_q;
      abort_d     = abort_q;
      case (state_q)
         EMU_IDLE: begin
            if (rise) begin
               state_d     = EMU_INTEG;
               integ_cnt_d = 32'd1;
            end
         end
         EMU_INTEG: begin
            if (fall) begin
               integ_len_d = integ_cnt_q;
               if (integ_cnt_q < MIN_INTEG) begin
                  short_d = 1'b1;
                  state_d = EMU_IDLE;
               end else begin
                  dly_cnt_d = 8'd0;
                  state_d   = EMU_DLY;
               end
            end else if (reset_in && (integ_cnt_q != 32'hFFFF_FFFF)) begin
               integ_cnt_d = integ_cnt_q + 32'd1;
            end
         end
         EMU_DLY: begin
            if (!rise) begin
               if (({1'b0, dly_cnt_q} + 9'd2) >= {1'b0, SP_DLY}) begin
                  state_d = EMU_SP;
                  ad_sp_d = 1'b1;
               end else begin
                  dly_cnt_d = dly_cnt_q + 8'd1;
               end
            end
         end
         EMU_SP: begin
            if (!rise) begin
               mode_d  = pattern_sel;
               const_d = const_val;
               pix_d   = 9'd0;
               data_d  = pat_data;
               valid_d = 1'b1;
               state_d = EMU_READ;
            end
         end
         EMU_READ: begin
            if (!rise) begin
               if (pix_q == PIX_NUM) begin
                  valid_d = 1'b0;
                  frame_d = frame_q + 16'd1;
                  state_d = EMU_IDLE;
               end else begin
                  pix_d  = pix_q + 9'd1;
                  data_d = pat_data;
               end
            end
         end
         default: state_d = EMU_IDLE;
      endcase
      // A new integration pulse during delay or readout abandons the line and starts a fresh one.
      if (rise && (state_q == EMU_DLY || state_q == EMU_SP || state_q == EMU_READ)) begin
         abort_d     = 1'b1;
         valid_d     = 1'b0;
         integ_cnt_d = 32'd1;
         state_d     = EMU_INTEG;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMU_IDLE;
         reset_d_q   <= 1'b0;
         integ_cnt_q <= '0;
         dly_cnt_q   <= '0;
         mode_q      <= '0;
         const_q     <= '0;
         ad_sp_q     <= 1'b0;
         valid_q     <= 1'b0;
         data_q      <= '0;
         pix_q       <= '0;
         integ_len_q <= '0;
         frame_q     <= '0;
         short_q     <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         reset_d_q   <= reset_d_d;
         integ_cnt_q <= integ_cnt_d;
         dly_cnt_q   <= dly_cnt_d;
         mode_q      <= mode_d;
         const_q     <= const_d;
         ad_sp_q     <= ad_sp_d;
         valid_q     <= valid_d;
         data_q      <= data_d;
         pix_q       <= pix_d;
         integ_len_q <= integ_len_d;
         frame_q     <= frame_d;
         short_q     <= short_d;
         abort_q     <= abort_d;
      end
   end

   assign ad_sp_o       = ad_sp_q;
   assign video_valid_o = valid_q & ~rise;
   assign video_data_o  = data_q;
   assign pix_idx_o     = pix_q;
   assign integ_len_o   = integ_len_q;
   assign frame_cnt_o   = frame_q;
   assign short_err_o   = short_q;
   assign abort_err_o   = abort_q;

endmodule
